zhegalkin_pipe: RTL and testbench

- Pipelined, parametrised Zhegalkin (algebraic normal form, Möbius over GF(2)) transform engine for Boolean functions of N variables.
- Input is a 2^N-bit truth table; output is the 2^N-bit ANF coefficient vector plus the algebraic degree of the result.
- Has one registered butterfly stage per variable and a valid/ready stream interface on both sides with full back-pressure.
- A per-transaction mode bit selects the forward (subset) transform or the dual (superset) transform.

---
 rtl/zhegalkin_pkg.sv | 43 ++++
 rtl/zhegalkin_stage.sv | 42 ++++
 rtl/zhegalkin_pipe.sv | 67 ++++++
 tb/tb_zhegalkin_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zhegalkin_pkg.sv
// Shared helpers for the Zhegalkin (ANF / Moebius over GF(2)) transform pipeline.
// Vectors are handled at the maximum supported width and narrowed by the users.
package zhegalkin_pkg;

    localparam int unsigned MaxN = 8;
    localparam int unsigned MaxW = 1 << MaxN;

    function automatic int unsigned tt_width(input int unsigned n);
        return 1 << n;
    endfunction

    function automatic int unsigned deg_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned popcount(input int unsigned index);
        int unsigned cnt;
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            cnt += (index >> k) & 32'd1;
        end
        return cnt;
    endfunction

    // One butterfly for variable s: mode 0 folds subsets downward, mode 1 folds supersets upward.
    function automatic logic [MaxW-1:0] butterfly(input logic [MaxW-1:0] w,
                                                  input int unsigned s,
                                                  input logic mode);
        logic [MaxW-1:0] r;
        int span;
        span = 1 << s;
        r = w;
        for (int i = 0; i < MaxW; i++) begin
            if (!mode && ((i >> s) & 1) == 1) begin
                r[i] = w[i] ^ w[i - span];
            end else if (mode && ((i >> s) & 1) == 0) begin
                r[i] = w[i] ^ w[i + span];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/zhegalkin_stage.sv
// One registered butterfly stage of the Zhegalkin pipeline (variable S).
// Invalid slots load zeros so the pipeline output reads 0 whenever it is not valid.
module zhegalkin_stage
    import zhegalkin_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned S = 0,
    localparam int unsigned W = tt_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_mode
);

    logic [MaxW-1:0] bf_full;

    assign bf_full = butterfly(MaxW'(in_data), S, in_mode);

    if (W < MaxW) begin : g_unused
        logic unused_bf;
        assign unused_bf = ^bf_full[MaxW-1:W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_data  <= in_valid ? bf_full[W-1:0] : '0;
            out_mode  <= in_valid & in_mode;
        end
    end

endmodule

// File: rtl/zhegalkin_pipe.sv
// Pipelined Zhegalkin transform: one butterfly stage per variable, global-stall
// valid/ready handshake, and a combinational algebraic-degree search on the result.
module zhegalkin_pipe
    import zhegalkin_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned W = tt_width(N),
    localparam int unsigned DW = deg_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_mode,
    output logic [DW-1:0] out_degree
);

    logic                  advance;
    logic [N:0]            stage_valid;
    logic [N:0]            stage_mode;
    logic [N:0][W-1:0]     stage_data;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    assign stage_valid[0] = in_valid & advance;
    assign stage_data[0]  = in_data;
    assign stage_mode[0]  = in_mode;

    for (genvar s = 0; s < N; s++) begin : g_stage
        zhegalkin_stage #(
            .N(N),
            .S(s)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .advance  (advance),
            .in_valid (stage_valid[s]),
            .in_data  (stage_data[s]),
            .in_mode  (stage_mode[s]),
            .out_valid(stage_valid[s+1]),
            .out_data (stage_data[s+1]),
            .out_mode (stage_mode[s+1])
        );
    end

    assign out_valid = stage_valid[N];
    assign out_data  = stage_data[N];
    assign out_mode  = stage_mode[N];

    always_comb begin
        logic [DW-1:0] deg;
        deg = '0;
        for (int u = 0; u < W; u++) begin
            if (out_data[u] && popcount(u) > 32'(deg)) begin
                deg = DW'(popcount(u));
            end
        end
        out_degree = deg;
    end

endmodule

// File: tb/tb_zhegalkin_pipe.sv
// Directed bench for zhegalkin_pipe at N=3, with a short randomised scoreboard run
// checked against a direct subset/superset-sum ANF model.
module tb_zhegalkin_pipe;

    localparam int unsigned N  = 3;
    localparam int unsigned W  = 8;
    localparam int unsigned DW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_mode;
    logic [DW-1:0] out_degree;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    zhegalkin_pipe #(
        .N(N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_degree(out_degree)
    );

    function automatic logic [W-1:0] ref_anf(input logic [W-1:0] f, input logic mode);
        logic [W-1:0] r;
        r = '0;
        for (int u = 0; u < W; u++) begin
            for (int x = 0; x < W; x++) begin
                if (!mode && (x & ~u) == 0) r[u] = r[u] ^ f[x];
                if (mode && (u & ~x) == 0) r[u] = r[u] ^ f[x];
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_degree(input logic [W-1:0] c);
        int d;
        d = 0;
        for (int u = 0; u < W; u++) begin
            if (c[u] && $countones(u) > d) d = $countones(u);
        end
        return DW'(d);
    endfunction

    // Sends one word into an idle pipeline and waits (bounded) for its result.
    task automatic apply_word(input logic [W-1:0] d, input logic m,
                              output logic [W-1:0] od, output logic om,
                              output logic [DW-1:0] odeg, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        od   = out_data;
        om   = out_mode;
        odeg = out_degree;
    endtask

    task automatic test_reset();
        logic seen;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        if (out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode: got %b want 0", out_mode); end
        if (out_degree !== 2'd0) begin errors++; $display("FAIL reset_out_degree: got %0d want 0", out_degree); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_ignored_input: got out_valid 1 want 0"); end
    endtask

    task automatic test_forward();
        logic [W-1:0]  vin [4] = '{8'hFF, 8'h80, 8'hAA, 8'h96};
        logic [W-1:0]  vexp[4] = '{8'h01, 8'h80, 8'h02, 8'h16};
        logic [DW-1:0] vdeg[4] = '{2'd0, 2'd3, 2'd1, 2'd1};
        logic [W-1:0]  od;
        logic          om;
        logic [DW-1:0] odeg;
        int            lat;
        for (int k = 0; k < 4; k++) begin
            apply_word(vin[k], 1'b0, od, om, odeg, lat);
            checks += 4;
            if (lat !== 3) begin errors++; $display("FAIL fwd_latency[%0d]: got %0d want 3", k, lat); end
            if (od !== vexp[k]) begin errors++; $display("FAIL fwd_data[%0d]: got %h want %h", k, od, vexp[k]); end
            if (odeg !== vdeg[k]) begin errors++; $display("FAIL fwd_degree[%0d]: got %0d want %0d", k, odeg, vdeg[k]); end
            if (om !== 1'b0) begin errors++; $display("FAIL fwd_mode[%0d]: got %b want 0", k, om); end
        end
    endtask

    task automatic test_involution();
        logic [W-1:0]  od;
        logic          om;
        logic [DW-1:0] odeg;
        int            lat;
        apply_word(8'h16, 1'b0, od, om, odeg, lat);
        checks++;
        if (od !== 8'h96) begin errors++; $display("FAIL invol_fwd: got %h want 96", od); end
        apply_word(8'hFF, 1'b1, od, om, odeg, lat);
        checks++;
        if (od !== 8'h80) begin errors++; $display("FAIL invol_dual: got %h want 80", od); end
    endtask

    task automatic test_dual();
        logic [W-1:0]  od;
        logic          om;
        logic [DW-1:0] odeg;
        int            lat;
        apply_word(8'h80, 1'b1, od, om, odeg, lat);
        checks += 3;
        if (od !== 8'hFF) begin errors++; $display("FAIL dual_and_data: got %h want FF", od); end
        if (om !== 1'b1) begin errors++; $display("FAIL dual_and_mode: got %b want 1", om); end
        if (odeg !== 2'd3) begin errors++; $display("FAIL dual_and_degree: got %0d want 3", odeg); end
        apply_word(8'h01, 1'b1, od, om, odeg, lat);
        checks += 3;
        if (od !== 8'h01) begin errors++; $display("FAIL dual_one_data: got %h want 01", od); end
        if (om !== 1'b1) begin errors++; $display("FAIL dual_one_mode: got %b want 1", om); end
        if (odeg !== 2'd0) begin errors++; $display("FAIL dual_one_degree: got %0d want 0", odeg); end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0]  words[5] = '{8'h80, 8'hAA, 8'h96, 8'h80, 8'hFF};
        logic          modes[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0]  vexp [5] = '{8'h80, 8'h02, 8'h16, 8'hFF, 8'h01};
        logic [DW-1:0] vdeg [5] = '{2'd3, 2'd1, 2'd1, 2'd3, 2'd0};
        int   acc = 0;
        int   got = 0;
        logic hold_bad = 1'b0;
        logic dup = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = 1'b1;
            in_data  = words[acc];
            in_mode  = modes[acc];
            #1;
            if (cyc >= 3 && (out_valid !== 1'b1 || out_data !== 8'h80 || out_degree !== 2'd3))
                hold_bad = 1'b1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        checks += 3;
        if (acc !== 3) begin errors++; $display("FAIL bp_accepted_while_stalled: got %0d want 3", acc); end
        if (hold_bad) begin errors++; $display("FAIL bp_stall_hold: got unstable output want 80 held"); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            in_valid = (acc < 5);
            if (acc < 5) begin
                in_data = words[acc];
                in_mode = modes[acc];
            end
            #1;
            if (out_valid) begin
                checks += 2;
                if (out_data !== vexp[got]) begin
                    errors++;
                    $display("FAIL bp_order_data[%0d]: got %h want %h", got, out_data, vexp[got]);
                end
                if (out_degree !== vdeg[got]) begin
                    errors++;
                    $display("FAIL bp_order_degree[%0d]: got %0d want %0d", got, out_degree, vdeg[got]);
                end
                got++;
            end
            if (in_valid && in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) begin
            #1;
            if (out_valid !== 1'b0) dup = 1'b1;
            @(negedge clk);
        end
        checks += 2;
        if (got !== 5) begin errors++; $display("FAIL bp_result_count: got %0d want 5", got); end
        if (dup) begin errors++; $display("FAIL bp_no_duplicate: got extra out_valid want none"); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h80;
        in_mode   = 1'b0;
        @(negedge clk);
        in_data = 8'hAA;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL midreset_out_data: got %h want 00", out_data); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midreset_stale: got stale result want none"); end
    endtask

    task automatic test_random();
        logic [W:0]   sb[$];
        logic [W:0]   e;
        logic         stall_prev = 1'b0;
        logic [W-1:0] prev_data = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                in_data   = 8'($urandom);
                in_mode   = ($urandom_range(0, 1) == 1);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL rnd_stall_hold: got %b/%h want 1/%h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected: got %h want no result", out_data);
                end else begin
                    e = sb.pop_front();
                    if ({out_mode, out_data} !== e || out_degree !== ref_degree(e[W-1:0])) begin
                        errors++;
                        $display("FAIL rnd_result: got %b/%h/%0d want %b/%h/%0d", out_mode, out_data,
                                 out_degree, e[W], e[W-1:0], ref_degree(e[W-1:0]));
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back({in_mode, ref_anf(in_data, in_mode)});
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_forward();
        test_involution();
        test_dual();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
